multu_hilo: RTL
===============

MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; HI/LO are each WIDTH bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT (signed), 10 MTHI, 11 MTLO.
REQ-006 SHALL have port dataA  input  WIDTH  multiplicand (rs); also the MTHI/MTLO source.
REQ-007 SHALL have port dataB  input  WIDTH  multiplier (rt).
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress; the pipeline stalls on it.
REQ-009 SHALL have port done  output  1  one-cycle pulse after HI/LO take a product.
REQ-010 SHALL have port hi  output  WIDTH  HI register, driven directly from the flop.
REQ-011 SHALL have port lo  output  WIDTH  LO register, driven directly from the flop.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, SIGN, DONE.
REQ-013 In IDLE with start=1 and op[1]=0, SHALL capture the operands and move to CALC at the next edge.
  - MULTU: operands captured as unsigned values.
  - MULT: captures |dataA| and |dataB| as WIDTH-bit unsigned values (0x80000000 -> 0x80000000).
  - MULT: records neg = dataA[MSB] XOR dataB[MSB].
  - MULTU: neg = 0.
REQ-014 CALC SHALL run exactly WIDTH cycles of shift-add on a 2*WIDTH-bit product register, one multiplier bit per cycle.
  - Each cycle: if the current LSB is 1, add the multiplicand into the upper half using a WIDTH+1-bit sum that keeps the carry.
  - Then shift the product right by one.
REQ-015 SHALL hold the iteration count in a counter that wraps from WIDTH-1 to 0; after the last iteration the FSM SHALL move to SIGN.
REQ-016 SIGN SHALL last one cycle.
  - Writes {hi,lo} = neg ? two's-complement negation of the product (full 2*WIDTH bits) : product.
  - Then moves to DONE.
REQ-017 DONE SHALL last one cycle: done=1, busy=0; then move to IDLE.
REQ-018 busy SHALL be 1 in CALC and SIGN only, i.e. 33 cycles for WIDTH=32.
REQ-019 done SHALL be 1 in DONE only.
REQ-020 Latency: HI/LO show the product 34 cycles after the start edge.
REQ-021 hi/lo SHALL keep their previous values through CALC and change only at the SIGN-to-DONE edge.
REQ-022 start SHALL be ignored in CALC, SIGN and DONE; no queueing.
  - A start asserted in DONE is lost.
  - A new op is accepted the following cycle (IDLE).
REQ-023 In IDLE with start=1 and op=10, SHALL load hi<=dataA at the next edge; lo unchanged, no busy, no done, FSM stays IDLE.
REQ-024 In IDLE with start=1 and op=11, SHALL load lo<=dataA likewise; hi unchanged.
REQ-025 In IDLE with start=0, SHALL change no state.
REQ-026 Operands captured at start SHALL be used for the whole operation; dataA/dataB changes during busy have no effect.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, product register=0, neg=0.
REQ-028 Reset mid-operation SHALL abort the multiply and discard partial results.
  - The first edge with rst=0 SHALL evaluate start in IDLE.

Structure
REQ-029 The op encodings (MULTU/MULT/MTHI/MTLO) and the FSM state encodings SHALL reside in the shared MIPS definitions package/include, not locally.
REQ-030 SHALL instantiate one sub-module, hilo_adder: a combinational WIDTH-bit adder with carry-out, used for the CALC add; the FSM, counter and registers stay in multu_hilo.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles; done pulses at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT 0xFFFFFFFE (-2) x 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each; busy and done stay 0.
REQ-034 MULTU 7x6 with start re-pulsed at cycles 5 and 33 and in the DONE cycle -> a single result only, hi=0, lo=42; the DONE-cycle start is dropped.
REQ-035 Reset mid-operation:
  - Preload hi=0xAAAAAAAA via MTHI.
  - Start MULTU, then assert rst at cycle 10 between clock edges.
  - Expect busy=0 and hi=lo=0 at once.
  - After release, MULTU 3x5 -> lo=15.
REQ-036 MULT 0x00000000 x 0x80000000 and MULTU 0 x 0 -> hi=lo=0, with full 34-cycle timing (no early exit).

Source files
------------

// File: rtl/multu_hilo_pkg.sv
// Shared MIPS HI/LO definitions: op encodings and multiplier FSM states.
package multu_hilo_pkg;

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpMthi  = 2'b10,
        OpMtlo  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StSign = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/hilo_adder.sv
// Combinational WIDTH-bit adder with carry-out, used for the shift-add step.
module hilo_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/multu_hilo.sv
// Iterative MIPS MULT/MULTU unit with HI/LO registers and MTHI/MTLO writes.
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;
    op_e                op_s;

    assign op_s = op_e'(op);

    hilo_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i     (prod_q[2*WIDTH-1:WIDTH]),
        .b_i     (mcand_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    unique case (op_s)
                        OpMultu: begin
                            mcand_d = dataA;
                            prod_d  = {{WIDTH{1'b0}}, dataB};
                            neg_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = StCalc;
                        end
                        OpMult: begin
                            // Magnitudes only; the most negative value maps onto itself.
                            mcand_d = dataA[WIDTH-1] ? -dataA : dataA;
                            prod_d  = {{WIDTH{1'b0}}, (dataB[WIDTH-1] ? -dataB : dataB)};
                            neg_d   = dataA[WIDTH-1] ^ dataB[WIDTH-1];
                            cnt_d   = '0;
                            state_d = StCalc;
                        end
                        OpMthi: hi_d = dataA;
                        OpMtlo: lo_d = dataA;
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (prod_q[0]) begin
                    prod_d = {add_carry, add_sum, prod_q[WIDTH-1:1]};
                end else begin
                    prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
                end
                cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
                state_d      = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == StCalc) || (state_q == StSign);
    assign done = (state_q == StDone);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
